nonce_selector: RTL and testbench
=================================

// Module: nonce_selector
// PURPOSE
//  Downstream stage of the bitcoin hash engine. After that block writes one h0 word per nonce
//  to memory, this block reads them back and finds the smallest h0 and its nonce. It also
//  counts the h0 values below a difficulty target and writes a 3-word summary to memory.
//  It shares the single-port memory after the hash engine asserts done.
// PARAMETERS
//  NUM_NONCES  16  number of consecutive h0 words to scan (2..256)
//  IDX_W       5   width of nonce index / hit count; must hold NUM_NONCES
// PORTS
//  clk             in   1   system clock; all state updates on rising edge
//  reset           in   1   asynchronous reset, active-high
//  start           in   1   begin a scan; sampled only in IDLE or DONE
//  hash_addr       in   16  address of h0 for nonce 0; nonce i at hash_addr+i
//  result_addr     in   16  base address of the 3-word summary
//  target          in   32  difficulty target; a hit is h0 < target (unsigned, strict)
//  done            out  1   scan and summary write complete; held until next start
//  found           out  1   hit count != 0; valid while done=1
//  best_nonce      out  IDX_W  index of the smallest h0; valid while done=1
//  mem_clk         out  1   = clk
//  mem_we          out  1   memory write enable
//  mem_addr        out  16  memory address (registered)
//  mem_write_data  out  32  memory write data (registered)
//  mem_read_data   in   32  synchronous read data: valid to be sampled on the 2nd rising edge after mem_addr is registered
// BEHAVIOUR
//  - Reset (any time, including mid-scan): state=IDLE. done, found, mem_we, mem_addr,
//    mem_write_data, best_nonce, min register and hit count all 0. The in-flight scan is discarded.
//  - States: IDLE -> READ -> DRAIN -> WR0 -> WR1 -> WR2 -> DONE.
//    DONE -> READ on start; start is ignored in every other non-IDLE state.
//  - Edge E0 samples start: mem_addr<=hash_addr, rd_idx<=1, cmp_idx<=0, hits<=0, done<=0, mem_we<=0.
//  - READ: each edge mem_addr<=hash_addr+rd_idx and rd_idx++. Goes to DRAIN after address NUM_NONCES-1 is issued.
//    The read pipeline delivers one word per cycle, with no bubbles.
//  - The word for the address registered at edge k is compared at edge k+2.
//    Compare order is cmp_idx = 0..NUM_NONCES-1.
//  - Min tracking: word 0 always loads min/best. A later word replaces them only if strictly smaller,
//    so on a tie the lowest index wins.
//  - Hits: hits++ when word < target. hits saturates at 2^IDX_W-1.
//  - DRAIN: lasts until the last word has been compared (edge NUM_NONCES+1).
//  - WR0/WR1/WR2 (edges N+2..N+4), mem_we=1, one word per edge, in this order:
//    result_addr+0 <= min h0; result_addr+1 <= zero-extended best_nonce;
//    result_addr+2 <= zero-extended hits.
//  - Edge N+5: mem_we<=0, done<=1, found<=(hits!=0), state=DONE.
//    Latency from start edge to done high = NUM_NONCES+5 clocks (21 at default).
//  - Addresses wrap modulo 2^16 (hash_addr+i overflow wraps silently).
//  - mem_we is never high outside WR0..WR2. No reads are issued in WR*/DONE/IDLE;
//    mem_addr holds its last value there.
// TESTING
//  1. h0[i]=0x1000_0000-i (i=0..15), target=0x0FFF_FFF8 -> min=0x0FFF_FFF1, best_nonce=15, hits=7, found=1;
//     done exactly 21 clocks after start.
//  2. all h0=0xFFFF_FFFF, target=0xFFFF_FFFF -> min=0xFFFF_FFFF, best_nonce=0, hits=0, found=0.
//  3. h0[3]=h0[9]=0x0000_0005, others 0x8000_0000, target=0x8000_0000 -> best_nonce=3, hits=2.
//  4. reset asserted at cycle 8 of a scan -> all outputs 0 next edge, no mem_we pulse, state IDLE.
//     A new start then gives the correct summary.
//  5. start held high through the whole scan -> single scan, exactly 3 write cycles.
//     In DONE, start re-launches the scan and done drops on that edge.
//  6. hash_addr=0xFFF8 -> reads wrap to 0x0000..0x0007; summary matches the memory contents.

Source files
------------

// File: rtl/nonce_selector.sv
// nonce_selector: reads back NUM_NONCES h0 words, tracks the smallest h0 and
// its nonce, counts hits below target and writes a 3-word summary to memory.
module nonce_selector #(
   parameter int NUM_NONCES = 16,
   parameter int IDX_W      = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      hash_addr,
   input  logic [15:0]      result_addr,
   input  logic [31:0]      target,
   output logic             done,
   output logic             found,
   output logic [IDX_W-1:0] best_nonce,
   output logic             mem_clk,
   output logic             mem_we,
   output logic [15:0]      mem_addr,
   output logic [31:0]      mem_write_data,
   input  logic [31:0]      mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_WR0,
      S_WR1,
      S_WR2,
      S_DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NONCES - 1);
   localparam logic [IDX_W-1:0] HMAX = '1;

   state_t           r_state;
   logic [IDX_W-1:0] r_rd_idx;
   logic [IDX_W-1:0] r_cmp_idx;
   logic [IDX_W-1:0] r_hits;
   logic [31:0]      r_min;
   logic [31:0]      r_target;
   logic [15:0]      r_hash_addr;
   logic [15:0]      r_res_addr;
   logic             r_v0;
   logic             r_v1;

   logic [15:0]      w_rd_addr;
   logic             w_first;
   logic             w_less;
   logic             w_hit;

   assign mem_clk   = clk;
   assign w_rd_addr = r_hash_addr + 16'(r_rd_idx);
   assign w_first   = (r_cmp_idx == '0);
   assign w_less    = (mem_read_data < r_min);
   assign w_hit     = (mem_read_data < r_target);

   // r_v0/r_v1 track an issued address through the two-cycle read latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_rd_idx       <= '0;
         r_cmp_idx      <= '0;
         r_hits         <= '0;
         r_min          <= '0;
         r_target       <= '0;
         r_hash_addr    <= '0;
         r_res_addr     <= '0;
         r_v0           <= 1'b0;
         r_v1           <= 1'b0;
         done           <= 1'b0;
         found          <= 1'b0;
         best_nonce     <= '0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
      end else begin
         r_v1 <= r_v0;
         r_v0 <= 1'b0;
         if (r_v1) begin
            if (w_first || w_less) begin
               r_min      <= mem_read_data;
               best_nonce <= r_cmp_idx;
            end
            if (w_hit && (r_hits != HMAX))
               r_hits <= r_hits + IDX_W'(1);
            r_cmp_idx <= r_cmp_idx + IDX_W'(1);
         end
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_hash_addr <= hash_addr;
                  r_res_addr  <= result_addr;
                  r_target    <= target;
                  mem_addr    <= hash_addr;
                  r_rd_idx    <= IDX_W'(1);
                  r_cmp_idx   <= '0;
                  r_hits      <= '0;
                  r_v0        <= 1'b1;
                  done        <= 1'b0;
                  found       <= 1'b0;
                  mem_we      <= 1'b0;
                  r_state     <= S_READ;
               end
            end
            S_READ: begin
               mem_addr <= w_rd_addr;
               r_rd_idx <= r_rd_idx + IDX_W'(1);
               r_v0     <= 1'b1;
               if (r_rd_idx == LAST)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!r_v0 && !r_v1) begin
                  mem_we         <= 1'b1;
                  mem_addr       <= r_res_addr;
                  mem_write_data <= r_min;
                  r_state        <= S_WR0;
               end
            end
            S_WR0: begin
               mem_addr       <= r_res_addr + 16'd1;
               mem_write_data <= 32'(best_nonce);
               r_state        <= S_WR1;
            end
            S_WR1: begin
               mem_addr       <= r_res_addr + 16'd2;
               mem_write_data <= 32'(r_hits);
               r_state        <= S_WR2;
            end
            S_WR2: begin
               mem_we  <= 1'b0;
               done    <= 1'b1;
               found   <= (r_hits != '0);
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nonce_selector.sv
// tb_nonce_selector: memory model plus scoreboard; each launched scan pushes
// its expected summary, which is popped and compared when done rises.
module tb_nonce_selector;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] hash_addr;
   logic [15:0] result_addr;
   logic [31:0] target;
   logic        done;
   logic        found;
   logic [4:0]  best_nonce;
   logic        mem_clk;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   nonce_selector #(.NUM_NONCES(16), .IDX_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .hash_addr      (hash_addr),
      .result_addr    (result_addr),
      .target         (target),
      .done           (done),
      .found          (found),
      .best_nonce     (best_nonce),
      .mem_clk        (mem_clk),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:65535];
   logic [31:0] rd_q = '0;
   int unsigned wr_total = 0;

   always @(posedge clk) begin
      rd_q <= mem[mem_addr];
      if (mem_we) begin
         mem[mem_addr] = mem_write_data;
         wr_total <= wr_total + 1;
      end
   end
   assign mem_read_data = rd_q;

   typedef struct {
      logic [31:0] min;
      logic [4:0]  best;
      logic [4:0]  hits;
      logic        found;
      logic [15:0] raddr;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] ha,
                                  input logic [15:0] ra,
                                  input logic [31:0] tg);
      exp_t e;
      logic [31:0] w;
      e.min = '0;
      e.best = '0;
      e.hits = '0;
      e.raddr = ra;
      for (int i = 0; i < 16; i++) begin
         w = mem[16'(ha + 16'(i))];
         if (i == 0 || w < e.min) begin
            e.min  = w;
            e.best = 5'(i);
         end
         if (w < tg && e.hits != 5'h1f)
            e.hits = e.hits + 5'd1;
      end
      e.found = (e.hits != 0);
      return e;
   endfunction

   task automatic prep(input logic [15:0] ha, input logic [15:0] ra,
                       input logic [31:0] tg);
      @(negedge clk);
      hash_addr   = ha;
      result_addr = ra;
      target      = tg;
      for (int i = 0; i < 3; i++)
         mem[16'(ra + 16'(i))] = 32'hDEAD_BEEF;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      forever begin
         @(posedge clk);
         lat++;
         #1;
         if (done) break;
         if (lat > 200) begin
            chk("done_timeout", {31'd0, done}, 32'd1);
            break;
         end
      end
   endtask

   task automatic score(input int lat, input int unsigned w0);
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("latency", 32'(lat), 32'd21);
      chk("best_nonce", {27'd0, best_nonce}, {27'd0, e.best});
      chk("found", {31'd0, found}, {31'd0, e.found});
      chk("wr_min", mem[e.raddr], e.min);
      chk("wr_best", mem[16'(e.raddr + 16'd1)], {27'd0, e.best});
      chk("wr_hits", mem[16'(e.raddr + 16'd2)], {27'd0, e.hits});
      chk("we_cycles", wr_total - w0, 32'd3);
   endtask

   task automatic run(input logic [15:0] ha, input logic [15:0] ra,
                      input logic [31:0] tg, input bit hold);
      int lat;
      int unsigned w0;
      prep(ha, ra, tg);
      w0 = wr_total;
      sb.push_back(model(ha, ra, tg));
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      wait_done(lat);
      score(lat, w0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_found"}, {31'd0, found}, 32'd0);
      chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
      chk({tag, "_wdata"}, mem_write_data, 32'd0);
      chk({tag, "_best"}, {27'd0, best_nonce}, 32'd0);
   endtask

   initial begin
      int lat;
      int unsigned w0;
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      reset = 1'b1;
      start = 1'b0;
      hash_addr = '0;
      result_addr = '0;
      target = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // descending words: last nonce is smallest, 7 below target
      for (int i = 0; i < 16; i++)
         mem[16'h0010 + i] = 32'h1000_0000 - 32'(i);
      run(16'h0010, 16'h0040, 32'h0FFF_FFF8, 1'b0);
      chk("t1_min_k", mem[16'h0040], 32'h0FFF_FFF1);
      chk("t1_best_k", mem[16'h0041], 32'd15);
      chk("t1_hits_k", mem[16'h0042], 32'd7);

      for (int i = 0; i < 16; i++)
         mem[16'h0100 + i] = 32'hFFFF_FFFF;
      run(16'h0100, 16'h0140, 32'hFFFF_FFFF, 1'b0);
      chk("t2_hits_k", mem[16'h0142], 32'd0);

      // tie between nonces 3 and 9: lower index wins
      for (int i = 0; i < 16; i++)
         mem[16'h0200 + i] = 32'h8000_0000;
      mem[16'h0203] = 32'd5;
      mem[16'h0209] = 32'd5;
      run(16'h0200, 16'h0240, 32'h8000_0000, 1'b0);
      chk("t3_best_k", mem[16'h0241], 32'd3);
      chk("t3_hits_k", mem[16'h0242], 32'd2);

      // reset in the middle of a scan
      for (int i = 0; i < 16; i++)
         mem[16'h0300 + i] = $urandom;
      prep(16'h0300, 16'h0340, 32'h4000_0000);
      w0 = wr_total;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk_zero("abort");
      @(posedge clk);
      #1;
      chk_zero("abort_edge");
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("abort_no_we", wr_total - w0, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      run(16'h0300, 16'h0340, 32'h4000_0000, 1'b0);

      // start held high, then relaunch from DONE
      for (int i = 0; i < 16; i++)
         mem[16'h0400 + i] = $urandom_range(32'h0FFF_FFFF, 0);
      run(16'h0400, 16'h0440, 32'h0800_0000, 1'b1);
      w0 = wr_total;
      sb.push_back(model(16'h0400, 16'h0440, 32'h0800_0000));
      @(posedge clk);
      #1;
      chk("relaunch_done_low", {31'd0, done}, 32'd0);
      start = 1'b0;
      wait_done(lat);
      score(lat, w0);

      // address wrap past 0xFFFF
      for (int i = 0; i < 8; i++) begin
         mem[16'hFFF8 + i] = $urandom;
         mem[i] = $urandom;
      end
      run(16'hFFF8, 16'h0500, 32'h8000_0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
